mov_avg_filter_v2: RTL and testbench
====================================

MOV_AVG_FILTER_V2 -- requirements
Module: mov_avg_filter_v2

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed sample width.
REQ-002 SHALL have parameter LOG2_N, default 6: window depth N = 2**LOG2_N, legal range 1..10.
REQ-003 SHALL have parameter ROUND, default 0: 0 = floor (arithmetic shift), 1 = round half up.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port clear, input, 1: synchronous flush of the window.
REQ-007 SHALL have port in_valid, input, 1: sample strobe.
REQ-008 SHALL have port in_data, input, DATA_W: signed sample.
REQ-009 SHALL have port out_valid, output, 1: result strobe.
REQ-010 SHALL have port out_data, output, DATA_W: signed window average.
REQ-011 SHALL have port primed, output, 1: high once N samples have been accepted since the last reset or clear.

Function
REQ-012 SHALL keep a running sum of width DATA_W+LOG2_N signed, updated only on in_valid cycles; no per-cycle N-term adder tree.
REQ-013 On accepted sample: sum_next = sum + in_data - oldest.
- oldest = ring[wr_ptr] in RUN, 0 in FILL.
- ring[wr_ptr] <= in_data.
- wr_ptr increments modulo N, wrapping N-1 -> 0.
REQ-014 out_data SHALL be sum_next >>> LOG2_N (ROUND=0) or (sum_next + 2**(LOG2_N-1)) >>> LOG2_N (ROUND=1), registered.
- Latency 1 cycle: out_valid pulses the cycle after each in_valid.
- No overflow is possible; no saturation logic.
REQ-015 FILL state: fill counter (LOG2_N+1 bits) counts accepted samples; primed low; outputs are still produced (missing taps treated as 0).
REQ-016 FILL -> RUN on the sample that makes fill = N; primed goes high in the same cycle out_valid first reports the full-window average.
REQ-017 RUN state: remains until reset or clear; fill counter holds.
REQ-018 in_valid low: sum, wr_ptr, ring, state unchanged; out_valid low; out_data holds its last value.
REQ-019 clear high: sum, wr_ptr and fill -> 0; state -> FILL; out_valid low next cycle. Ring contents are not erased.
REQ-020 clear and in_valid together: clear wins; the sample is discarded.
REQ-021 Back-to-back in_valid every cycle SHALL be sustained with no stall.

Reset
REQ-022 While rst_n is low at a clk edge: sum=0, wr_ptr=0, fill=0, state=FILL, out_valid=0, out_data=0, primed=0.
REQ-023 Reset mid-window SHALL discard all history; the first post-reset sample yields in_data >>> LOG2_N (ROUND=0).
REQ-024 Ring memory SHALL NOT require reset; FILL masking makes stale contents invisible.

Structure
REQ-025 Shared package mov_avg_pkg SHALL hold the FILL/RUN state encoding and the default DATA_W/LOG2_N values.
REQ-026 Ring storage SHALL be one sub-module, sample_ring: N x DATA_W, one synchronous write port, one asynchronous read port addressed by wr_ptr.

Verification
REQ-027 DATA_W=8, LOG2_N=2, ROUND=0: samples 4,8,12,16,20 every cycle.
- out_data 1,3,6,10,14.
- primed rises with the 4th output.
REQ-028 Same config, ROUND=1: samples 1,1,1,1.
- out_data 0,1,1,1.
- Floor variant gives 0,0,0,1.
REQ-029 Sign check, ROUND=0: four samples of -128 -> out_data -32,-64,-96,-128; four samples of 127 follow -> final output 127, no wrap.
REQ-030 Sparse/simultaneous events:
- in_valid gapped 1-in-3 gives the same values as REQ-027.
- clear asserted together with a sample of 50 -> no out_valid; next sample 8 -> out_data 2, primed 0.
REQ-031 Reset mid-run after 10 samples: next sample 40 -> out_data 10.
REQ-032 Default config (DATA_W=8, LOG2_N=6): constant stream of 100 for 200 cycles.
- Outputs rise monotonically to 100, reaching 100 at sample 64.
- Output stays at 100.
- wr_ptr wraps three times without glitch.

Source files
------------

// File: rtl/mov_avg_pkg.sv
// Shared definitions for the moving-average filter: window state encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mov_avg_pkg;

  // Window state: FILL while fewer than N samples are held, RUN once the window is full.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LOG2_N = 6;

endpackage

// File: rtl/mov_avg_filter_v2_sample_ring.sv
// Sample ring: N x DATA_W storage holding the most recent window of samples.
// Latency: write lands on the next clk edge; the read is combinational from rd_addr.
// Backpressure: none; accepts a write on every cycle wr_en is high.
module sample_ring #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  localparam int DEPTH = 1 << ADDR_W;

  // Contents are never reset; FILL masking in the filter hides stale entries.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/mov_avg_filter_v2.sv
// Moving average over the last 2**LOG2_N samples using a running sum and a sample ring.
// Latency: one cycle from in_valid to out_valid; out_data holds between results.
// Backpressure: none; a sample may be accepted every cycle, clear discards a concurrent sample.
module mov_avg_filter_v2
  import mov_avg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2_N = DEF_LOG2_N,
  parameter int ROUND  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     primed
);

  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;

  // Rounding bias is half an LSB of the shifted result; the sum width always has room for it.
  localparam logic signed [SUM_W-1:0] HALF      = SUM_W'(ROUND != 0 ? N / 2 : 0);
  localparam logic        [LOG2_N:0]  FILL_FULL = (LOG2_N + 1)'(N);

  state_e                     state_q, state_d;
  logic signed [SUM_W-1:0]    sum_q, sum_d;
  logic        [LOG2_N-1:0]   wr_ptr_q, wr_ptr_d;
  logic        [LOG2_N:0]     fill_q, fill_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]   out_data_q, out_data_d;

  logic                       ring_wr_en;
  logic        [DATA_W-1:0]   ring_rd_dat;
  logic signed [DATA_W-1:0]   oldest;
  logic signed [SUM_W-1:0]    in_ext;
  logic signed [SUM_W-1:0]    old_ext;
  logic signed [SUM_W-1:0]    sum_next;
  logic signed [SUM_W-1:0]    acc;
  logic                       unused_frac;

  sample_ring #(
    .DATA_W (DATA_W),
    .ADDR_W (LOG2_N)
  ) u_ring (
    .clk     (clk),
    .wr_en   (ring_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_dat  (in_data),
    .rd_addr (wr_ptr_q),
    .rd_dat  (ring_rd_dat)
  );

  // Datapath: the slot about to be overwritten leaves the sum, but only once the window is full.
  always_comb begin
    oldest = '0;
    if (state_q == ST_RUN) begin
      oldest = ring_rd_dat;
    end
    in_ext   = {{LOG2_N{in_data[DATA_W-1]}}, in_data};
    old_ext  = {{LOG2_N{oldest[DATA_W-1]}}, oldest};
    sum_next = sum_q + in_ext - old_ext;
    acc      = sum_next + HALF;
  end

  // Dropping the low LOG2_N bits of the two's-complement sum is the arithmetic shift (floor).
  assign unused_frac = ^acc[LOG2_N-1:0];

  // Next-state: clear wins over a concurrent sample; idle cycles hold everything but out_valid.
  always_comb begin
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    state_d     = state_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    ring_wr_en  = 1'b0;
    if (clear) begin
      sum_d    = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
      state_d  = ST_FILL;
    end else if (in_valid) begin
      ring_wr_en  = 1'b1;
      sum_d       = sum_next;
      wr_ptr_d    = wr_ptr_q + LOG2_N'(1);
      out_valid_d = 1'b1;
      out_data_d  = acc[SUM_W-1:LOG2_N];
      if (state_q == ST_FILL) begin
        fill_d = fill_q + (LOG2_N + 1)'(1);
        if (fill_d == FILL_FULL) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  // State registers with synchronous active-low reset; ring storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign primed    = (state_q == ST_RUN);

endmodule

// File: tb/tb_mov_avg_filter_v2.sv
// Bench for mov_avg_filter_v2: three configurations driven by one shared stimulus stream.
module tb_mov_avg_filter_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n    = 1'b0;
  logic              clear    = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_data  = '0;

  logic              a_vld, b_vld, c_vld;
  logic              a_pr, b_pr, c_pr;
  logic signed [7:0] a_dat, b_dat, c_dat;

  int checks   = 0;
  int failures = 0;

  // A: N=4 floor, B: N=4 round-half-up, C: default N=64 floor.
  mov_avg_filter_v2 #(.DATA_W(8), .LOG2_N(2), .ROUND(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(a_vld), .out_data(a_dat), .primed(a_pr));
  mov_avg_filter_v2 #(.DATA_W(8), .LOG2_N(2), .ROUND(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(b_vld), .out_data(b_dat), .primed(b_pr));
  mov_avg_filter_v2 dut_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(c_vld), .out_data(c_dat), .primed(c_pr));

  // Reference model: the list of samples accepted since the last reset/clear.
  int  hist[$];
  int  cnt     = 0;
  bit  exp_vld = 1'b0;
  int  exp_dat[3];
  int  cfg_n[3]   = '{4, 4, 64};
  bit  cfg_rnd[3] = '{1'b0, 1'b1, 1'b0};
  bit  chk_en     = 1'b0;

  int  log_a[$], log_b[$], log_c[$];
  int  pr_a[$], pr_c[$];

  function automatic int floor_div(int s, int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int window_avg(int n, bit rnd);
    int s = 0;
    int k = (hist.size() < n) ? hist.size() : n;
    for (int i = 0; i < k; i++) s += hist[hist.size() - 1 - i];
    return rnd ? floor_div(s + n / 2, n) : floor_div(s, n);
  endfunction

  function automatic int at(int q[$], int i);
    if (i < 0 || i >= q.size()) return -9999;
    return q[i];
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Apply the inputs that the DUT just sampled on this edge to the model.
  task automatic model_update();
    if (!rst_n) begin
      hist.delete();
      cnt     = 0;
      exp_vld = 1'b0;
      for (int i = 0; i < 3; i++) exp_dat[i] = 0;
    end else if (clear) begin
      hist.delete();
      cnt     = 0;
      exp_vld = 1'b0;
    end else if (in_valid) begin
      hist.push_back(int'(in_data));
      if (hist.size() > 64) void'(hist.pop_front());
      cnt++;
      exp_vld = 1'b1;
      for (int i = 0; i < 3; i++) exp_dat[i] = window_avg(cfg_n[i], cfg_rnd[i]);
    end else begin
      exp_vld = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic c, input logic v, input logic signed [7:0] d);
    @(posedge clk);
    model_update();
    #1;
    rst_n    = r;
    clear    = c;
    in_valid = v;
    in_data  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'sd0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 8'sd0);
    step(1'b0, 1'b0, 1'b0, 8'sd0);
    step(1'b1, 1'b0, 1'b0, 8'sd0);
    log_a.delete(); log_b.delete(); log_c.delete(); pr_a.delete(); pr_c.delete();
  endtask

  // Compare every DUT output against the model on each falling edge, and log results.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("a_vld", int'(a_vld), int'(exp_vld));
        chk("b_vld", int'(b_vld), int'(exp_vld));
        chk("c_vld", int'(c_vld), int'(exp_vld));
        chk("a_dat", int'(a_dat), exp_dat[0]);
        chk("b_dat", int'(b_dat), exp_dat[1]);
        chk("c_dat", int'(c_dat), exp_dat[2]);
        chk("a_pr", int'(a_pr), int'(cnt >= cfg_n[0]));
        chk("b_pr", int'(b_pr), int'(cnt >= cfg_n[1]));
        chk("c_pr", int'(c_pr), int'(cnt >= cfg_n[2]));
        if (a_vld) begin log_a.push_back(int'(a_dat)); pr_a.push_back(int'(a_pr)); end
        if (b_vld) log_b.push_back(int'(b_dat));
        if (c_vld) begin log_c.push_back(int'(c_dat)); pr_c.push_back(int'(c_pr)); end
      end
    end
  end

  initial begin
    int exp_q[$];
    int n0;
    int mono_bad;
    int flat_bad;

    do_reset();
    chk("rst_a_vld", int'(a_vld), 0);
    chk("rst_a_dat", int'(a_dat), 0);
    chk("rst_a_pr", int'(a_pr), 0);
    chk("rst_c_pr", int'(c_pr), 0);
    chk_en = 1'b1;

    // Back-to-back 4,8,12,16,20 on N=4.
    exp_q = '{1, 3, 6, 10, 14};
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b1, 8'(4 * i));
    idle(2);
    chk("b2b_len", log_a.size(), 5);
    for (int i = 0; i < 5; i++) chk("b2b_dat", at(log_a, i), exp_q[i]);
    chk("b2b_pr3", at(pr_a, 2), 0);
    chk("b2b_pr4", at(pr_a, 3), 1);

    // Ones: round-half-up vs floor.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'sd1);
    idle(2);
    exp_q = '{0, 1, 1, 1};
    for (int i = 0; i < 4; i++) chk("round_dat", at(log_b, i), exp_q[i]);
    exp_q = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) chk("floor_dat", at(log_a, i), exp_q[i]);

    // Extremes: full negative window, then full positive window.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, -8'sd128);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'sd127);
    idle(2);
    exp_q = '{-32, -64, -96, -128};
    for (int i = 0; i < 4; i++) chk("neg_dat", at(log_a, i), exp_q[i]);
    chk("pos_final", at(log_a, 7), 127);

    // Gapped 1-in-3 gives the same results as back-to-back.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'(4 * i));
      idle(2);
    end
    exp_q = '{1, 3, 6, 10, 14};
    for (int i = 0; i < 5; i++) chk("gap_dat", at(log_a, i), exp_q[i]);

    // Clear together with a sample: sample discarded, window restarts.
    n0 = log_a.size();
    step(1'b1, 1'b1, 1'b1, 8'sd50);
    idle(2);
    chk("clr_no_vld", log_a.size(), n0);
    step(1'b1, 1'b0, 1'b1, 8'sd8);
    idle(2);
    chk("clr_next_dat", at(log_a, log_a.size() - 1), 2);
    chk("clr_next_pr", at(pr_a, pr_a.size() - 1), 0);

    // Reset in the middle of a run discards history.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
    step(1'b0, 1'b0, 1'b0, 8'sd0);
    step(1'b1, 1'b0, 1'b1, 8'sd40);
    idle(2);
    chk("rst_mid_a", at(log_a, log_a.size() - 1), 10);
    chk("rst_mid_c", at(log_c, log_c.size() - 1), 0);

    // Constant 100 on the N=64 default configuration.
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b1, 8'sd100);
    idle(2);
    chk("const_len", log_c.size(), 200);
    chk("const_62", at(log_c, 62), 98);
    chk("const_63", at(log_c, 63), 100);
    chk("const_199", at(log_c, 199), 100);
    chk("const_pr62", at(pr_c, 62), 0);
    chk("const_pr63", at(pr_c, 63), 1);
    mono_bad = 0;
    flat_bad = 0;
    for (int i = 1; i < log_c.size(); i++) if (log_c[i] < log_c[i-1]) mono_bad++;
    for (int i = 63; i < log_c.size(); i++) if (log_c[i] != 100) flat_bad++;
    chk("const_monotonic", mono_bad, 0);
    chk("const_flat", flat_bad, 0);

    // Random traffic with occasional clear and reset; the model checks every cycle.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
